// File: rtl/mmu_data_arb_pkg.sv
// Shared types for the MMU data-side arbiter: outstanding-queue entry layout
// and the port-id width helper.
package mmu_data_arb_pkg;

  // Wide enough for the largest supported port count (8).
  localparam int ID_W = 3;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            discard;
  } arb_qent_t;

  function automatic int port_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmu_data_arb_id_queue.sv
// In-order FIFO of outstanding request owners; a bulk discard marks every
// resident entry so flushed responses can be swallowed on the way out.
module arb_id_queue
  import mmu_data_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  arb_qent_t push_ent,
  input  logic      pop,
  input  logic      mark_all_discard,
  output logic      full,
  output logic      empty,
  output arb_qent_t head
);
  localparam int PW = $clog2(DEPTH);

  arb_qent_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // Marking stale slots too is harmless: a push rewrites the whole entry.
      if (mark_all_discard)
        for (int i = 0; i < DEPTH; i++) mem[i].discard <= 1'b1;
      if (do_push) begin
        mem[wr_ptr] <= push_ent;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmu_data_arb.sv
// Round-robin arbiter of translated data ports onto the single data SRAM bus,
// with in-order response routing back to the issuing port and flush discard.
module mmu_data_arb
  import mmu_data_arb_pkg::*;
#(
  parameter int NPORT = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NPORT-1:0]       d_valid,
  input  logic [NPORT-1:0]       d_we,
  input  logic [NPORT-1:0][1:0]  d_size,
  input  logic [NPORT-1:0][3:0]  d_wstrb,
  input  logic [NPORT-1:0][31:0] d_pa,
  input  logic [NPORT-1:0][31:0] d_wdata,
  output logic [NPORT-1:0]       d_addr_ok,
  output logic [NPORT-1:0]       d_data_ok,
  output logic [31:0]            d_rdata,
  input  logic                   cancel,
  output logic                   proto_err,
  output logic                   data_sram_req,
  output logic                   data_sram_wr,
  output logic [1:0]             data_sram_size,
  output logic [3:0]             data_sram_wstrb,
  output logic [31:0]            data_sram_addr,
  output logic [31:0]            data_sram_wdata,
  input  logic                   data_sram_addr_ok,
  input  logic                   data_sram_data_ok,
  input  logic [31:0]            data_sram_rdata
);
  localparam int PW = port_id_w(NPORT);

  logic [PW-1:0] rr_ptr, grant, cand, rr_next, lock_port;
  logic          lock_q, found;
  logic          accept, pop, resp_ok;
  logic          q_full, q_empty;
  arb_qent_t     head;

  // First requesting port at or after rr_ptr; a stalled grant stays pinned
  // while its owner keeps d_valid up so the bus sees a stable request.
  always_comb begin
    grant = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      cand = PW'((int'(rr_ptr) + i) % NPORT);
      if (!found && d_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
    if (lock_q && d_valid[lock_port]) grant = lock_port;
  end

  assign rr_next = (grant == PW'(NPORT-1)) ? '0 : grant + 1'b1;

  assign data_sram_req   = (|d_valid) && !q_full && !cancel && !reset;
  assign data_sram_wr    = d_we[grant];
  assign data_sram_size  = d_size[grant];
  assign data_sram_wstrb = d_wstrb[grant];
  assign data_sram_addr  = d_pa[grant];
  assign data_sram_wdata = d_wdata[grant];

  assign accept  = data_sram_req && data_sram_addr_ok;
  assign pop     = data_sram_data_ok && !q_empty && !reset;
  // A head popped under cancel belongs to a flushed request as well.
  assign resp_ok = pop && !head.discard && !cancel;
  assign d_rdata = data_sram_rdata;

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    assign d_addr_ok[p] = accept && (grant == PW'(p));
    assign d_data_ok[p] = resp_ok && (head.id == ID_W'(p));
  end

  arb_id_queue #(.DEPTH(DEPTH)) u_idq (
    .clk              (clk),
    .reset            (reset),
    .push             (accept),
    .push_ent         ('{id: ID_W'(grant), discard: 1'b0}),
    .pop              (pop),
    .mark_all_discard (cancel),
    .full             (q_full),
    .empty            (q_empty),
    .head             (head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= '0;
      lock_q    <= 1'b0;
      lock_port <= '0;
      proto_err <= 1'b0;
    end else begin
      if (accept) rr_ptr <= rr_next;
      lock_q    <= data_sram_req && !data_sram_addr_ok;
      lock_port <= grant;
      if (data_sram_data_ok && q_empty) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mmu_data_arb.sv
// Self-checking bench for mmu_data_arb: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_mmu_data_arb;
  localparam int NPORT = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic [NPORT-1:0]       d_valid, d_we, d_addr_ok, d_data_ok;
  logic [NPORT-1:0][1:0]  d_size;
  logic [NPORT-1:0][3:0]  d_wstrb;
  logic [NPORT-1:0][31:0] d_pa, d_wdata;
  logic [31:0]            d_rdata;
  logic cancel, proto_err;
  logic data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic data_sram_addr_ok, data_sram_data_ok;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mmu_data_arb #(.NPORT(NPORT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .d_valid(d_valid), .d_we(d_we), .d_size(d_size), .d_wstrb(d_wstrb),
    .d_pa(d_pa), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .cancel(cancel), .proto_err(proto_err),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata)
  );

  // Reference model: list of outstanding owners with a flushed flag each.
  int   m_id[$];
  bit   m_disc[$];
  int   m_rr;
  bit   m_lk;
  int   m_lk_port;
  bit   m_perr;
  int   e_g;
  bit   e_req, e_pop;
  logic [NPORT-1:0] e_aok, e_dok;

  function automatic void model_reset();
    m_id.delete(); m_disc.delete();
    m_rr = 0; m_lk = 0; m_lk_port = 0; m_perr = 0;
  endfunction

  function automatic void model_eval();
    e_g = 0;
    if (m_lk && d_valid[m_lk_port]) e_g = m_lk_port;
    else
      for (int i = NPORT-1; i >= 0; i--)
        if (d_valid[(m_rr + i) % NPORT]) e_g = (m_rr + i) % NPORT;
    e_req = (d_valid != 0) && (m_id.size() < DEPTH) && !cancel;
    e_aok = (e_req && data_sram_addr_ok) ? NPORT'(1 << e_g) : '0;
    e_pop = data_sram_data_ok && (m_id.size() > 0);
    e_dok = (e_pop && !m_disc[0] && !cancel) ? NPORT'(1 << m_id[0]) : '0;
  endfunction

  function automatic void model_commit();
    if (data_sram_data_ok && m_id.size() == 0) m_perr = 1;
    if (e_pop) begin void'(m_id.pop_front()); void'(m_disc.pop_front()); end
    if (cancel) foreach (m_disc[i]) m_disc[i] = 1;
    if (e_req && data_sram_addr_ok) begin
      m_id.push_back(e_g); m_disc.push_back(0);
      m_rr = (e_g + 1) % NPORT;
    end
    m_lk = e_req && !data_sram_addr_ok;
    m_lk_port = e_g;
  endfunction

  task automatic clear_inputs();
    d_valid = '0; d_we = '0; d_size = '0; d_wstrb = '0; d_pa = '0; d_wdata = '0;
    cancel = 0; data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    d_valid = 2'b11;
    #1;
    checks++;
    if (data_sram_req !== 1'b0 || d_addr_ok !== 2'b00 || d_data_ok !== 2'b00 || proto_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: req=%b aok=%b dok=%b perr=%b required all 0",
               data_sram_req, d_addr_ok, d_data_ok, proto_err);
    end
    do_reset();
  endtask

  task automatic test_alternate();
    logic [31:0] rd;
    do_reset();
    d_valid = 2'b11; d_pa[0] = 32'h0000_1000; d_pa[1] = 32'h0000_2000;
    data_sram_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (d_addr_ok !== ((i % 2 == 0) ? 2'b01 : 2'b10) ||
          data_sram_addr !== ((i % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000)) begin
        failures++;
        $display("FAIL alt_grant[%0d]: aok=%b addr=%h", i, d_addr_ok, data_sram_addr);
      end
      @(posedge clk); #1;
    end
    d_valid = '0; data_sram_addr_ok = 0;
    for (int i = 0; i < 4; i++) begin
      rd = $urandom;
      data_sram_data_ok = 1; data_sram_rdata = rd;
      @(negedge clk);
      checks++;
      if (d_data_ok !== ((i % 2 == 0) ? 2'b01 : 2'b10) || d_rdata !== rd) begin
        failures++;
        $display("FAIL alt_resp[%0d]: dok=%b rdata=%h required rdata %h", i, d_data_ok, d_rdata, rd);
      end
      @(posedge clk); #1;
    end
    data_sram_data_ok = 0;
  endtask

  task automatic test_lock();
    do_reset();
    d_valid = 2'b10; d_pa[1] = 32'h1C00_0100; d_pa[0] = 32'h1C00_0200;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) d_valid = 2'b11;
      @(negedge clk);
      checks++;
      if (data_sram_req !== 1'b1 || data_sram_addr !== 32'h1C00_0100 || d_addr_ok !== 2'b00) begin
        failures++;
        $display("FAIL lock_hold[%0d]: req=%b addr=%h aok=%b required 1/1c000100/00",
                 i, data_sram_req, data_sram_addr, d_addr_ok);
      end
      @(posedge clk); #1;
    end
    data_sram_addr_ok = 1;
    @(negedge clk);
    checks++;
    if (d_addr_ok !== 2'b10 || data_sram_addr !== 32'h1C00_0100) begin
      failures++;
      $display("FAIL lock_accept: aok=%b addr=%h required 10/1c000100", d_addr_ok, data_sram_addr);
    end
    @(posedge clk); #1;
    d_valid = 2'b01;
    @(negedge clk);
    checks++;
    if (d_addr_ok !== 2'b01 || data_sram_addr !== 32'h1C00_0200) begin
      failures++;
      $display("FAIL lock_next: aok=%b addr=%h required 01/1c000200", d_addr_ok, data_sram_addr);
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_full();
    do_reset();
    d_valid = 2'b01; data_sram_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (data_sram_req !== 1'b1 || d_addr_ok !== 2'b01) begin
        failures++;
        $display("FAIL full_fill[%0d]: req=%b aok=%b required 1/01", i, data_sram_req, d_addr_ok);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (data_sram_req !== 1'b0 || d_addr_ok !== 2'b00) begin
      failures++;
      $display("FAIL full_block: req=%b aok=%b required 0/00", data_sram_req, d_addr_ok);
    end
    @(posedge clk); #1;
    data_sram_data_ok = 1;
    @(negedge clk);
    checks++;
    if (data_sram_req !== 1'b0 || d_data_ok !== 2'b01) begin
      failures++;
      $display("FAIL full_pop: req=%b dok=%b required 0/01", data_sram_req, d_data_ok);
    end
    @(posedge clk); #1;
    data_sram_data_ok = 0;
    @(negedge clk);
    checks++;
    if (data_sram_req !== 1'b1) begin
      failures++;
      $display("FAIL full_reassert: req=%b required 1", data_sram_req);
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_cancel();
    do_reset();
    d_valid = 2'b01; data_sram_addr_ok = 1;
    repeat (2) @(posedge clk);
    #1 cancel = 1;
    @(negedge clk);
    checks++;
    if (data_sram_req !== 1'b0 || d_addr_ok !== 2'b00) begin
      failures++;
      $display("FAIL cancel_block: req=%b aok=%b required 0/00", data_sram_req, d_addr_ok);
    end
    @(posedge clk); #1;
    cancel = 0; d_valid = '0;
    data_sram_data_ok = 1; data_sram_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (d_data_ok !== 2'b00) begin
        failures++;
        $display("FAIL cancel_drop[%0d]: dok=%b required 00", i, d_data_ok);
      end
      @(posedge clk); #1;
    end
    data_sram_data_ok = 0;
    // Flush landing on the same cycle as the head's response.
    d_valid = 2'b01;
    @(posedge clk); #1;
    d_valid = '0; cancel = 1; data_sram_data_ok = 1;
    @(negedge clk);
    checks++;
    if (d_data_ok !== 2'b00) begin
      failures++;
      $display("FAIL cancel_same_cycle: dok=%b required 00", d_data_ok);
    end
    @(posedge clk); #1;
    cancel = 0; data_sram_data_ok = 0;
    @(negedge clk);
    checks++;
    if (proto_err !== 1'b0) begin
      failures++;
      $display("FAIL cancel_perr: proto_err=%b required 0", proto_err);
    end
    @(posedge clk); #1;
    data_sram_data_ok = 1;
    @(posedge clk); #1;
    data_sram_data_ok = 0;
    checks++;
    if (proto_err !== 1'b1) begin
      failures++;
      $display("FAIL cancel_empty: proto_err=%b required 1 (queue should be empty)", proto_err);
    end
  endtask

  task automatic test_proto_err();
    do_reset();
    data_sram_data_ok = 1;
    @(negedge clk);
    checks++;
    if (proto_err !== 1'b0 || d_data_ok !== 2'b00) begin
      failures++;
      $display("FAIL perr_early: proto_err=%b dok=%b required 0/00", proto_err, d_data_ok);
    end
    @(posedge clk); #1;
    data_sram_data_ok = 0; d_valid = 2'b01; data_sram_addr_ok = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (proto_err !== 1'b1) begin
        failures++;
        $display("FAIL perr_sticky[%0d]: proto_err=%b required 1", i, proto_err);
      end
      @(posedge clk); #1;
    end
    do_reset();
    checks++;
    if (proto_err !== 1'b0) begin
      failures++;
      $display("FAIL perr_clear: proto_err=%b required 0", proto_err);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    d_valid = 2'b01; data_sram_addr_ok = 1;
    repeat (3) @(posedge clk);
    #1 data_sram_data_ok = 1;
    @(negedge clk);
    #1 reset = 1;
    #1;
    checks++;
    if (data_sram_req !== 1'b0 || d_addr_ok !== 2'b00 || d_data_ok !== 2'b00 || proto_err !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: req=%b aok=%b dok=%b perr=%b required all 0",
               data_sram_req, d_addr_ok, d_data_ok, proto_err);
    end
    @(posedge clk); #1;
    reset = 0; d_valid = '0; data_sram_addr_ok = 0;
    @(posedge clk); #1;
    data_sram_data_ok = 0;
    checks++;
    if (proto_err !== 1'b1) begin
      failures++;
      $display("FAIL async_reset_empty: proto_err=%b required 1 (queue should be empty)", proto_err);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < NPORT; p++)
        if (!d_valid[p] && $urandom_range(0, 2) == 0) begin
          d_valid[p] = 1'b1;
          d_pa[p]    = $urandom;
          d_wdata[p] = $urandom;
          d_we[p]    = 1'($urandom);
          d_size[p]  = 2'($urandom_range(0, 2));
          d_wstrb[p] = 4'($urandom);
        end
      data_sram_addr_ok = ($urandom_range(0, 2) != 0);
      data_sram_data_ok = (m_id.size() > 0) && ($urandom_range(0, 1) == 1);
      data_sram_rdata   = $urandom;
      cancel            = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      model_eval();
      checks++;
      if (data_sram_req !== e_req || d_addr_ok !== e_aok || d_data_ok !== e_dok || proto_err !== m_perr) begin
        failures++;
        $display("FAIL rand_ctl[%0d]: req=%b aok=%b dok=%b perr=%b required %b/%b/%b/%b",
                 cyc, data_sram_req, d_addr_ok, d_data_ok, proto_err, e_req, e_aok, e_dok, m_perr);
      end
      if (e_req) begin
        checks++;
        if (data_sram_addr !== d_pa[e_g] || data_sram_wdata !== d_wdata[e_g] ||
            data_sram_wr !== d_we[e_g] || data_sram_size !== d_size[e_g] ||
            data_sram_wstrb !== d_wstrb[e_g]) begin
          failures++;
          $display("FAIL rand_fields[%0d]: addr=%h required %h (port %0d)",
                   cyc, data_sram_addr, d_pa[e_g], e_g);
        end
      end
      if (e_dok != 0) begin
        checks++;
        if (d_rdata !== data_sram_rdata) begin
          failures++;
          $display("FAIL rand_rdata[%0d]: rdata=%h required %h", cyc, d_rdata, data_sram_rdata);
        end
      end
      @(posedge clk); #1;
      model_commit();
      d_valid = d_valid & ~e_aok;
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_lock();
    test_full();
    test_cancel();
    test_proto_err();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
